// File: rtl/pipelined_shift_unit.sv
// rtl/pipelined_shift_unit.sv - pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready handshakes
// Optional macro SHIFT_CARRY_EN adds out_carry, the last bit shifted out.
module pipelined_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SHIFT_CARRY_EN
  output logic             out_carry,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = $clog2(WIDTH);
  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  logic              advance;
  logic              v_q [STAGES];
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [1:0]        m_q [STAGES];
  logic              s_q [STAGES];
  logic [STAGES-1:0] a_q [STAGES];
  logic [TAG_W-1:0]  t_q [STAGES];

  logic              sv [STAGES];
  logic [WIDTH-1:0]  sd [STAGES];
  logic [1:0]        sm [STAGES];
  logic              ss [STAGES];
  logic [STAGES-1:0] sa [STAGES];
  logic [TAG_W-1:0]  st [STAGES];
  logic [WIDTH-1:0]  nd [STAGES];

  logic [AMT_W-1:0]  amt_hi;
  logic [STAGES-1:0] amt_lo;
  logic              amt_sat;
  logic              amt_is_w;
  logic              in_sign;
  logic              sat_shift;

  assign amt_hi    = in_amt >> STAGES;
  assign amt_lo    = in_amt[STAGES-1:0];
  assign amt_sat   = |amt_hi;
  assign amt_is_w  = (amt_hi == AMT_W'(1)) && (amt_lo == '0);
  assign in_sign   = in_data[WIDTH-1];
  assign sat_shift = amt_sat && (in_mode != MODE_ROR);

  function automatic logic amt_bit(input logic [STAGES-1:0] a, input int b);
    logic [STAGES-1:0] t;
    t = a >> b;
    return t[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                                input logic s, input int k);
    logic [WIDTH-1:0] fill;
    fill = s ? ~({WIDTH{1'b1}} >> k) : '0;
    case (m)
      MODE_SLL: return d << k;
      MODE_SRL: return d >> k;
      MODE_SRA: return (d >> k) | fill;
      default:  return (d >> k) | (d << (WIDTH - k));
    endcase
  endfunction

`ifdef SHIFT_CARRY_EN
  logic c_q [STAGES];
  logic sc  [STAGES];
  logic nc  [STAGES];
  logic init_carry;

  // Saturated beats never shift again, so their carry is fixed at accept.
  always_comb begin
    init_carry = 1'b0;
    if (sat_shift) begin
      if (in_mode == MODE_SRA)      init_carry = in_sign;
      else if (amt_is_w)            init_carry = (in_mode == MODE_SLL) ? in_data[0] : in_sign;
    end
  end

  // Last bit out of a right shift/rotate by k is d[k-1]; for a rotate that is also the new MSB.
  function automatic logic carry_of(input logic [WIDTH-1:0] d, input logic [1:0] m, input int k);
    logic [WIDTH-1:0] t;
    t = (m == MODE_SLL) ? (d >> (WIDTH - k)) : (d >> (k - 1));
    return t[0];
  endfunction

  always_comb begin
    sc[0] = init_carry;
    for (int i = 1; i < STAGES; i++) sc[i] = c_q[i-1];
    for (int i = 0; i < STAGES; i++)
      nc[i] = amt_bit(sa[i], STAGES-1-i) ? carry_of(sd[i], sm[i], 1 << (STAGES-1-i)) : sc[i];
  end

  assign out_carry = c_q[STAGES-1];
`endif

  // Stage 0 resolves saturation up front so later stages only ever see in-range amounts.
  always_comb begin
    sv[0] = in_valid;
    sm[0] = in_mode;
    ss[0] = in_sign;
    st[0] = in_tag;
    sa[0] = sat_shift ? '0 : amt_lo;
    sd[0] = in_data;
    if (sat_shift) sd[0] = (in_mode == MODE_SRA) ? {WIDTH{in_sign}} : '0;
    for (int i = 1; i < STAGES; i++) begin
      sv[i] = v_q[i-1];
      sd[i] = d_q[i-1];
      sm[i] = m_q[i-1];
      ss[i] = s_q[i-1];
      sa[i] = a_q[i-1];
      st[i] = t_q[i-1];
    end
    for (int i = 0; i < STAGES; i++)
      nd[i] = amt_bit(sa[i], STAGES-1-i) ? shift_by(sd[i], sm[i], ss[i], 1 << (STAGES-1-i)) : sd[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= 1'b0;
        d_q[i] <= '0;
        m_q[i] <= '0;
        s_q[i] <= 1'b0;
        a_q[i] <= '0;
        t_q[i] <= '0;
`ifdef SHIFT_CARRY_EN
        c_q[i] <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        v_q[i] <= sv[i];
        // Payload moves only with a real beat, so bubbles leave the last result in place.
        if (sv[i]) begin
          d_q[i] <= nd[i];
          m_q[i] <= sm[i];
          s_q[i] <= ss[i];
          a_q[i] <= sa[i];
          t_q[i] <= st[i];
`ifdef SHIFT_CARRY_EN
          c_q[i] <= nc[i];
`endif
        end
      end
    end
  end

  assign advance   = !v_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_tag   = t_q[STAGES-1];

endmodule
